// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings: ctrl codes, main-control ALUOp values and R-type funct values.
// Used by the ALU, main control and the ALU op issue buffer.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_BNE  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SLLV = 4'd8;
    localparam logic [3:0] ALU_LUI  = 4'd9;
    localparam logic [3:0] ALU_ORI  = 4'd10;
    localparam logic [3:0] ALU_ILL  = 4'd15;

    localparam logic [2:0] ALUOP_ADD  = 3'b000;
    localparam logic [2:0] ALUOP_SUB  = 3'b001;
    localparam logic [2:0] ALUOP_RTYP = 3'b010;
    localparam logic [2:0] ALUOP_SLT  = 3'b011;
    localparam logic [2:0] ALUOP_BNE  = 3'b100;
    localparam logic [2:0] ALUOP_LUI  = 3'b101;
    localparam logic [2:0] ALUOP_ORI  = 3'b110;
    localparam logic [2:0] ALUOP_SLTU = 3'b111;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational ALUOp/funct -> ALU ctrl decoder.
// Unsupported R-type funct codes map to ALU_ILL with illegal_o set.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [3:0] ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = ALU_ILL;
        illegal_o = 1'b0;
        case (aluop_i)
            ALUOP_ADD:  ctrl_o = ALU_ADD;
            ALUOP_SUB:  ctrl_o = ALU_SUB;
            ALUOP_SLT:  ctrl_o = ALU_SLT;
            ALUOP_BNE:  ctrl_o = ALU_BNE;
            ALUOP_LUI:  ctrl_o = ALU_LUI;
            ALUOP_ORI:  ctrl_o = ALU_ORI;
            ALUOP_SLTU: ctrl_o = ALU_SLTU;
            default: begin
                case (funct_i)
                    FUNCT_ADD:  ctrl_o = ALU_ADD;
                    FUNCT_SUB:  ctrl_o = ALU_SUB;
                    FUNCT_AND:  ctrl_o = ALU_AND;
                    FUNCT_OR:   ctrl_o = ALU_OR;
                    FUNCT_SLT:  ctrl_o = ALU_SLT;
                    FUNCT_SLTU: ctrl_o = ALU_SLTU;
                    FUNCT_SLL:  ctrl_o = ALU_SLL;
                    FUNCT_SLLV: ctrl_o = ALU_SLLV;
                    default: begin
                        ctrl_o    = ALU_ILL;
                        illegal_o = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_op_issue.sv
// Decodes ALUOp/funct and issues {ctrl, shamt, operands} to the ALU through a 2-entry buffer.
// Counts accepted beats carrying an unsupported funct (saturating).
module alu_op_issue
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [2:0]          aluop_i,
    input  logic [5:0]          funct_i,
    input  logic [4:0]          shamt_i,
    input  logic [DATA_W-1:0]   src1_i,
    input  logic [DATA_W-1:0]   src2_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [3:0]          ctrl_o,
    output logic [4:0]          shamt_o,
    output logic [DATA_W-1:0]   src1_o,
    output logic [DATA_W-1:0]   src2_o,
    output logic                illegal_o,
    output logic [ERRCNT_W-1:0] illegal_cnt_o
);

    // Handshake: a beat moves on a side when its valid and ready are both high at the
    // rising edge; ready_o/valid_o depend only on the registered count.
    logic [3:0]          ctrl_q    [DEPTH];
    logic                illegal_q [DEPTH];
    logic [4:0]          shamt_q   [DEPTH];
    logic [DATA_W-1:0]   src1_q    [DEPTH];
    logic [DATA_W-1:0]   src2_q    [DEPTH];
    logic                head_q, tail_q;
    logic [1:0]          count_q, count_d;
    logic [ERRCNT_W-1:0] illegal_cnt_q;

    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    logic       push, pop, rd_idx;

    alu_ctrl_decode u_decode (
        .aluop_i   (aluop_i),
        .funct_i   (funct_i),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    assign ready_o = (count_q < 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 2'd1;
        else if (pop && !push)
            count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            count_q       <= 2'd0;
            illegal_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i]    <= '0;
                illegal_q[i] <= 1'b0;
                shamt_q[i]   <= '0;
                src1_q[i]    <= '0;
                src2_q[i]    <= '0;
            end
        end else begin
            if (push) begin
                ctrl_q[tail_q]    <= dec_ctrl;
                illegal_q[tail_q] <= dec_illegal;
                shamt_q[tail_q]   <= shamt_i;
                src1_q[tail_q]    <= src1_i;
                src2_q[tail_q]    <= src2_i;
                tail_q            <= ~tail_q;
                if (dec_illegal && (illegal_cnt_q != '1))
                    illegal_cnt_q <= illegal_cnt_q + ERRCNT_W'(1);
            end
            if (pop)
                head_q <= ~head_q;
            count_q <= count_d;
        end
    end

    // When empty the slot behind head is the entry popped last, so outputs keep showing it.
    assign rd_idx        = (count_q == 2'd0) ? ~head_q : head_q;
    assign ctrl_o        = ctrl_q[rd_idx];
    assign illegal_o     = illegal_q[rd_idx];
    assign shamt_o       = shamt_q[rd_idx];
    assign src1_o        = src1_q[rd_idx];
    assign src2_o        = src2_q[rd_idx];
    assign illegal_cnt_o = illegal_cnt_q;

endmodule
